// File: rtl/stat_rd_arb.sv
// Round-robin arbiter sharing stat_pkt's single read port between N_REQ requesters.
// One read in flight; a read with no rd_data_val_i within TIMEOUT cycles completes with an error.
module stat_rd_arb #(
    parameter int N_REQ   = 3,
    parameter int A_WIDTH = 3,
    parameter int D_WIDTH = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*A_WIDTH-1:0]   req_flow_num_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic [D_WIDTH-1:0]         ack_data_o,
    output logic                       ack_err_o,
    output logic                       busy_o,
    output logic [15:0]                err_cnt_o,
    output logic                       rd_stb_o,
    output logic [A_WIDTH-1:0]         rd_flow_num_o,
    input  logic [D_WIDTH-1:0]         rd_data_i,
    input  logic                       rd_data_val_i
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      gnt_q, gnt_nxt;
    logic [IW-1:0]      rr_ptr, rr_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic               stb_nxt, err_nxt, busy_nxt;
    logic [A_WIDTH-1:0] flow_nxt;
    logic [N_REQ-1:0]   ack_nxt;
    logic [D_WIDTH-1:0] data_nxt;
    logic [15:0]        cnt_nxt;

    logic [A_WIDTH-1:0] flow [N_REQ];
    for (genvar k = 0; k < N_REQ; k++) begin : g_flow
        assign flow[k] = req_flow_num_i[k*A_WIDTH +: A_WIDTH];
    end

    // The requester being acked this cycle is masked so a held request cannot win twice in a row.
    logic [N_REQ-1:0] eligible;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    pick;
    logic             pick_vld;

    always_comb begin
        eligible = req_i & ~ack_o;
        cand     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(rr_ptr) + i >= N_REQ) ? IW'(int'(rr_ptr) + i - N_REQ)
                                               : IW'(int'(rr_ptr) + i);
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_q;
        rr_nxt    = rr_ptr;
        timer_nxt = timer;
        stb_nxt   = 1'b0;
        flow_nxt  = rd_flow_num_o;
        ack_nxt   = '0;
        data_nxt  = '0;
        err_nxt   = 1'b0;
        busy_nxt  = busy_o;
        cnt_nxt   = err_cnt_o;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = WAIT;
                    gnt_nxt   = pick;
                    rr_nxt    = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                    timer_nxt = '0;
                    stb_nxt   = 1'b1;
                    flow_nxt  = flow[pick];
                    busy_nxt  = 1'b1;
                end
            end
            WAIT: begin
                // Data arriving on the last allowed cycle beats the timeout.
                if (rd_data_val_i) begin
                    state_nxt      = IDLE;
                    ack_nxt[gnt_q] = 1'b1;
                    data_nxt       = rd_data_i;
                    busy_nxt       = 1'b0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_nxt      = IDLE;
                    ack_nxt[gnt_q] = 1'b1;
                    err_nxt        = 1'b1;
                    busy_nxt       = 1'b0;
                    if (err_cnt_o != 16'hFFFF)
                        cnt_nxt = err_cnt_o + 16'd1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            gnt_q         <= '0;
            rr_ptr        <= '0;
            timer         <= '0;
            rd_stb_o      <= 1'b0;
            rd_flow_num_o <= '0;
            ack_o         <= '0;
            ack_data_o    <= '0;
            ack_err_o     <= 1'b0;
            busy_o        <= 1'b0;
            err_cnt_o     <= '0;
        end else begin
            state         <= state_nxt;
            gnt_q         <= gnt_nxt;
            rr_ptr        <= rr_nxt;
            timer         <= timer_nxt;
            rd_stb_o      <= stb_nxt;
            rd_flow_num_o <= flow_nxt;
            ack_o         <= ack_nxt;
            ack_data_o    <= data_nxt;
            ack_err_o     <= err_nxt;
            busy_o        <= busy_nxt;
            err_cnt_o     <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_stat_rd_arb.sv
// Directed bench for stat_rd_arb with a stat_pkt read model answering 2 cycles after rd_stb.
module tb_stat_rd_arb;
    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] flows;
    logic [N-1:0]    ack_o;
    logic [DW-1:0]   ack_data_o;
    logic            ack_err_o, busy_o, rd_stb_o;
    logic [15:0]     err_cnt_o;
    logic [AW-1:0]   rd_flow_num_o;
    logic [DW-1:0]   rd_data_i;
    logic            rd_data_val_i;

    stat_rd_arb #(.N_REQ(N), .A_WIDTH(AW), .D_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_flow_num_i(flows),
        .ack_o(ack_o), .ack_data_o(ack_data_o), .ack_err_o(ack_err_o), .busy_o(busy_o),
        .err_cnt_o(err_cnt_o), .rd_stb_o(rd_stb_o), .rd_flow_num_o(rd_flow_num_o),
        .rd_data_i(rd_data_i), .rd_data_val_i(rd_data_val_i)
    );

    always #5 clk = ~clk;

    // stat_pkt read model plus a directly driven val for race/stray pulses
    logic            model_en = 1'b1;
    logic            d1 = 1'b0, val_m = 1'b0;
    logic [AW-1:0]   fl1 = '0;
    logic [DW-1:0]   data_m = '0;
    logic [DW-1:0]   mem [8];
    logic            force_val = 1'b0;
    logic [DW-1:0]   force_data = '0;

    always @(posedge clk) begin
        d1     <= rd_stb_o & model_en;
        fl1    <= rd_flow_num_o;
        val_m  <= d1;
        data_m <= mem[fl1];
    end
    assign rd_data_val_i = val_m | force_val;
    assign rd_data_i     = force_val ? force_data : (val_m ? data_m : '0);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [N-1:0]  t_ack;
    logic [DW-1:0] t_data;
    logic          t_err, t_busy, t_found;
    logic [AW-1:0] t_flow, t_flow_ack;
    int            t_stbn, t_stb_at, t_val_at, t_ack_at;

    // Runs one transaction; k counts negedges from the call, optional val pulse at cycle pulse_at.
    task automatic run_txn(input int bound, input int pulse_at, input logic [DW-1:0] pdata);
        t_found = 1'b0; t_stbn = 0; t_stb_at = -1; t_val_at = -1; t_ack_at = -1;
        t_ack = '0; t_data = '0; t_err = 1'b0; t_busy = 1'b0; t_flow = '0; t_flow_ack = '0;
        for (int k = 1; k <= bound && !t_found; k++) begin
            @(negedge clk);
            force_val  = (k == pulse_at);
            force_data = (k == pulse_at) ? pdata : '0;
            #1;
            if (rd_stb_o) begin
                t_stbn++;
                t_flow = rd_flow_num_o;
                if (t_stb_at < 0) t_stb_at = k;
            end
            if (rd_data_val_i) t_val_at = k;
            if (ack_o != '0) begin
                t_found = 1'b1; t_ack = ack_o; t_data = ack_data_o; t_err = ack_err_o;
                t_busy = busy_o; t_ack_at = k; t_flow_ack = rd_flow_num_o;
            end
        end
        force_val = 1'b0;
        force_data = '0;
        chk("ack_seen", 64'(t_found), 64'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},  64'(ack_o),         64'(0));
        chk({tag, "_data"}, 64'(ack_data_o),    64'(0));
        chk({tag, "_err"},  64'(ack_err_o),     64'(0));
        chk({tag, "_busy"}, 64'(busy_o),        64'(0));
        chk({tag, "_ecnt"}, 64'(err_cnt_o),     64'(0));
        chk({tag, "_stb"},  64'(rd_stb_o),      64'(0));
        chk({tag, "_flow"}, 64'(rd_flow_num_o), 64'(0));
    endtask

    // One-cycle val pulse while IDLE must produce nothing.
    task automatic idle_pulse(input string tag);
        @(negedge clk);
        force_val = 1'b1;
        force_data = 32'hBAD0BAD0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                force_val = 1'b0;
                force_data = '0;
            end
            #1;
            chk({tag, "_ack"},  64'(ack_o),    64'(0));
            chk({tag, "_busy"}, 64'(busy_o),   64'(0));
            chk({tag, "_stb"},  64'(rd_stb_o), 64'(0));
        end
    endtask

    logic [DW-1:0] fair_data [3];

    initial begin
        foreach (mem[i]) mem[i] = '0;
        mem[1] = 32'h11111111; mem[2] = 32'h22222222; mem[3] = 32'h33333333;
        mem[5] = 32'hDEADBEEF; mem[6] = 32'h66666666; mem[7] = 32'h77777777;
        fair_data[0] = 32'h11111111; fair_data[1] = 32'h22222222; fair_data[2] = 32'h33333333;
        rst = 1'b1; req = '0; flows = '0;

        repeat (3) @(negedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;

        // single read
        flows = {3'd0, 3'd0, 3'd5};
        req = 3'b001;
        run_txn(20, 0, '0);
        req = '0;
        chk("single_ack",    64'(t_ack),      64'(3'b001));
        chk("single_data",   64'(t_data),     64'(32'hDEADBEEF));
        chk("single_err",    64'(t_err),      64'(0));
        chk("single_busy",   64'(t_busy),     64'(0));
        chk("single_nstb",   64'(t_stbn),     64'(1));
        chk("single_flow",   64'(t_flow),     64'(5));
        chk("single_fhold",  64'(t_flow_ack), 64'(5));
        chk("single_stb_at", 64'(t_stb_at),   64'(1));
        chk("single_val_at", 64'(t_val_at),   64'(3));
        chk("single_ack_at", 64'(t_ack_at),   64'(4));

        // fairness from a fresh RR pointer
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flows = {3'd3, 3'd2, 3'd1};
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            run_txn(20, 0, '0);
            chk("fair_ack",    64'(t_ack),    64'(3'b001 << (i % 3)));
            chk("fair_flow",   64'(t_flow),   64'((i % 3) + 1));
            chk("fair_data",   64'(t_data),   64'(fair_data[i % 3]));
            chk("fair_nstb",   64'(t_stbn),   64'(1));
            chk("fair_stb_at", 64'(t_stb_at), 64'(1));
        end
        req = '0;

        // timeout with silent model
        model_en = 1'b0;
        req = 3'b010;
        run_txn(30, 0, '0);
        req = '0;
        chk("to_ack",    64'(t_ack),     64'(3'b010));
        chk("to_err",    64'(t_err),     64'(1));
        chk("to_data",   64'(t_data),    64'(0));
        chk("to_ack_at", 64'(t_ack_at),  64'(17));
        chk("to_busy",   64'(t_busy),    64'(0));
        chk("to_ecnt",   64'(err_cnt_o), 64'(1));
        idle_pulse("late");

        // val on the 16th WAIT cycle beats the timeout
        req = 3'b010;
        run_txn(30, 16, 32'hCAFEF00D);
        req = '0;
        chk("race_ack",    64'(t_ack),     64'(3'b010));
        chk("race_err",    64'(t_err),     64'(0));
        chk("race_data",   64'(t_data),    64'(32'hCAFEF00D));
        chk("race_ack_at", 64'(t_ack_at),  64'(17));
        chk("race_ecnt",   64'(err_cnt_o), 64'(1));
        idle_pulse("stray");

        // reset in the middle of a read
        req = 3'b010;
        repeat (4) @(negedge clk);
        #1 chk("mid_busy", 64'(busy_o), 64'(1));
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 chk_zero("rst_wait");
        end
        rst = 1'b0;
        req = '0;
        idle_pulse("post_rst");
        model_en = 1'b1;
        flows = {3'd7, 3'd0, 3'd6};
        req = 3'b101;
        run_txn(20, 0, '0);
        chk("rr0_ack",  64'(t_ack),  64'(3'b001));
        chk("rr0_data", 64'(t_data), 64'(32'h66666666));
        run_txn(20, 0, '0);
        req = '0;
        chk("rr2_ack",  64'(t_ack),  64'(3'b100));
        chk("rr2_data", 64'(t_data), 64'(32'h77777777));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
